// File: rtl/sc_reg_general_pkg.sv
// Shared constants for the general-purpose multi-channel register:
// merge mode encodings and load counter sizing.
package sc_reg_general_pkg;
    localparam logic [1:0] MODE_OR  = 2'b00;
    localparam logic [1:0] MODE_AND = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;
    localparam logic [1:0] MODE_SEL = 2'b11;

    localparam int                    LOAD_CNT_W   = 8;
    localparam logic [LOAD_CNT_W-1:0] LOAD_CNT_MAX = 8'd255;
endpackage

// File: rtl/sc_reg_general_merge.sv
// Combinational reduction of the masked input channels into one word.
module sc_reg_general_merge
    import sc_reg_general_pkg::*;
#(
    parameter int RegGENERAL_DATAWIDTH = 8,
    parameter int RegGENERAL_CHANNELS  = 3
) (
    input  logic [RegGENERAL_CHANNELS*RegGENERAL_DATAWIDTH-1:0] data,
    input  logic [RegGENERAL_CHANNELS-1:0]                      mask,
    input  logic [1:0]                                          mode,
    output logic [RegGENERAL_DATAWIDTH-1:0]                     merged
);
    logic [RegGENERAL_CHANNELS-1:0][RegGENERAL_DATAWIDTH-1:0] chan;
    logic [RegGENERAL_DATAWIDTH-1:0] orAcc, andAcc, xorAcc, selAcc;

    assign chan = data;

    // Walk channels high to low so the lowest enabled index wins the select.
    always_comb begin
        orAcc  = '0;
        andAcc = '1;
        xorAcc = '0;
        selAcc = '0;
        for (int i = RegGENERAL_CHANNELS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                orAcc  = orAcc | chan[i];
                andAcc = andAcc & chan[i];
                xorAcc = xorAcc ^ chan[i];
                selAcc = chan[i];
            end
        end
    end

    always_comb begin
        merged = '0;
        case (mode)
            MODE_OR:  merged = orAcc;
            MODE_AND: merged = (|mask) ? andAcc : '0;
            MODE_XOR: merged = xorAcc;
            MODE_SEL: merged = selAcc;
            default:  merged = '0;
        endcase
    end
endmodule

// File: rtl/sc_reg_general_multi.sv
// Multi-channel loadable/shiftable register with load counter and change pulse.
// Optional registered parity output enabled by SC_REG_GENERAL_MULTI_PARITY_EN.
module sc_reg_general_multi
    import sc_reg_general_pkg::*;
#(
    parameter int RegGENERAL_DATAWIDTH = 8,
    parameter int RegGENERAL_CHANNELS  = 3
) (
    input  logic                                                SC_RegGENERAL_CLOCK_50,
    input  logic                                                SC_RegGENERAL_RESET_InHigh,
    input  logic                                                SC_RegGENERAL_clear_InLow,
    input  logic                                                SC_RegGENERAL_load_InLow,
    input  logic                                                SC_RegGENERAL_shift_InLow,
    input  logic                                                SC_RegGENERAL_serial_In,
    input  logic [1:0]                                          SC_RegGENERAL_mode_InBUS,
    input  logic [RegGENERAL_CHANNELS-1:0]                      SC_RegGENERAL_mask_InBUS,
    input  logic [RegGENERAL_CHANNELS*RegGENERAL_DATAWIDTH-1:0] SC_RegGENERAL_data_InBUS,
    output logic [RegGENERAL_DATAWIDTH-1:0]                     SC_RegGENERAL_data_OutBUS,
    output logic                                                SC_RegGENERAL_loadDone_Out,
    output logic                                                SC_RegGENERAL_changed_Out,
    output logic [LOAD_CNT_W-1:0]                               SC_RegGENERAL_loadCount_OutBUS
`ifdef SC_REG_GENERAL_MULTI_PARITY_EN
    ,
    output logic                                                SC_RegGENERAL_parity_Out
`endif
);
    logic [RegGENERAL_DATAWIDTH-1:0] mergedWord;
    logic [RegGENERAL_DATAWIDTH-1:0] nextData;
    logic                            loadTake;

    sc_reg_general_merge #(
        .RegGENERAL_DATAWIDTH(RegGENERAL_DATAWIDTH),
        .RegGENERAL_CHANNELS (RegGENERAL_CHANNELS)
    ) merge (
        .data  (SC_RegGENERAL_data_InBUS),
        .mask  (SC_RegGENERAL_mask_InBUS),
        .mode  (SC_RegGENERAL_mode_InBUS),
        .merged(mergedWord)
    );

    assign loadTake = SC_RegGENERAL_clear_InLow && !SC_RegGENERAL_load_InLow;

    // clear > load > shift > hold
    always_comb begin
        nextData = SC_RegGENERAL_data_OutBUS;
        if (!SC_RegGENERAL_clear_InLow)
            nextData = '0;
        else if (!SC_RegGENERAL_load_InLow)
            nextData = mergedWord;
        else if (!SC_RegGENERAL_shift_InLow)
            nextData = {SC_RegGENERAL_data_OutBUS[RegGENERAL_DATAWIDTH-2:0], SC_RegGENERAL_serial_In};
    end

    // The stored word doubles as the previous-cycle value for change detection.
    always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            SC_RegGENERAL_data_OutBUS      <= '0;
            SC_RegGENERAL_loadDone_Out     <= 1'b0;
            SC_RegGENERAL_changed_Out      <= 1'b0;
            SC_RegGENERAL_loadCount_OutBUS <= '0;
        end else begin
            SC_RegGENERAL_data_OutBUS  <= nextData;
            SC_RegGENERAL_changed_Out  <= (nextData != SC_RegGENERAL_data_OutBUS);
            SC_RegGENERAL_loadDone_Out <= loadTake;
            if (!SC_RegGENERAL_clear_InLow)
                SC_RegGENERAL_loadCount_OutBUS <= '0;
            else if (loadTake && SC_RegGENERAL_loadCount_OutBUS != LOAD_CNT_MAX)
                SC_RegGENERAL_loadCount_OutBUS <= SC_RegGENERAL_loadCount_OutBUS + 1'b1;
        end
    end

`ifdef SC_REG_GENERAL_MULTI_PARITY_EN
    always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh)
            SC_RegGENERAL_parity_Out <= 1'b0;
        else
            SC_RegGENERAL_parity_Out <= ^nextData;
    end
`else
    // Parity disabled: no port, no state.
`endif
endmodule

// File: tb/tb_sc_reg_general_multi.sv
// Directed table-driven bench for sc_reg_general_multi (W=8, C=3).
module tb_sc_reg_general_multi;
    logic        clk = 1'b0;
    logic        rst;
    logic        clearN, loadN, shiftN, serial;
    logic [1:0]  mode;
    logic [2:0]  mask;
    logic [23:0] data;
    logic [7:0]  dout;
    logic        loadDone, changed;
    logic [7:0]  loadCount;
`ifdef SC_REG_GENERAL_MULTI_PARITY_EN
    logic        parity;
`endif

    int total = 0;
    int passed = 0;

    always #10 clk = ~clk;

    sc_reg_general_multi #(.RegGENERAL_DATAWIDTH(8), .RegGENERAL_CHANNELS(3)) dut (
        .SC_RegGENERAL_CLOCK_50        (clk),
        .SC_RegGENERAL_RESET_InHigh    (rst),
        .SC_RegGENERAL_clear_InLow     (clearN),
        .SC_RegGENERAL_load_InLow      (loadN),
        .SC_RegGENERAL_shift_InLow     (shiftN),
        .SC_RegGENERAL_serial_In       (serial),
        .SC_RegGENERAL_mode_InBUS      (mode),
        .SC_RegGENERAL_mask_InBUS      (mask),
        .SC_RegGENERAL_data_InBUS      (data),
        .SC_RegGENERAL_data_OutBUS     (dout),
        .SC_RegGENERAL_loadDone_Out    (loadDone),
        .SC_RegGENERAL_changed_Out     (changed),
        .SC_RegGENERAL_loadCount_OutBUS(loadCount)
`ifdef SC_REG_GENERAL_MULTI_PARITY_EN
        ,
        .SC_RegGENERAL_parity_Out      (parity)
`endif
    );

    typedef struct {
        logic        clearN, loadN, shiftN, serial;
        logic [1:0]  mode;
        logic [2:0]  mask;
        logic [23:0] data;
        logic [7:0]  expOut;
        logic        expDone, expChg;
        logic [7:0]  expCnt;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    endtask

    task automatic checkAll(input string name, input int idx, input logic [7:0] o, input logic d,
                            input logic c, input logic [7:0] n);
        chk({name, ".out"}, idx, 32'(dout), 32'(o));
        chk({name, ".loadDone"}, idx, 32'(loadDone), 32'(d));
        chk({name, ".changed"}, idx, 32'(changed), 32'(c));
        chk({name, ".loadCount"}, idx, 32'(loadCount), 32'(n));
`ifdef SC_REG_GENERAL_MULTI_PARITY_EN
        chk({name, ".parity"}, idx, 32'(parity), 32'(^o));
`endif
    endtask

    task automatic idle();
        clearN = 1'b1; loadN = 1'b1; shiftN = 1'b1; serial = 1'b0;
        mode = 2'b00; mask = 3'b000; data = 24'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic c, logic l, logic s, logic sr, logic [1:0] md, logic [2:0] mk_,
                                logic [23:0] d, logic [7:0] o, logic dn, logic ch, logic [7:0] n);
        vec_t v;
        v.clearN = c; v.loadN = l; v.shiftN = s; v.serial = sr;
        v.mode = md; v.mask = mk_; v.data = d;
        v.expOut = o; v.expDone = dn; v.expChg = ch; v.expCnt = n;
        return v;
    endfunction

    initial begin
        //          clrN  ldN  shN  ser mode   mask    data          out   done chg cnt
        vecs[0]  = mk(1,  0,   1,   0, 2'b00, 3'b111, 24'h040201, 8'h07, 1, 1, 8'd1);
        vecs[1]  = mk(1,  1,   1,   0, 2'b00, 3'b111, 24'h040201, 8'h07, 0, 0, 8'd1);
        vecs[2]  = mk(1,  0,   1,   0, 2'b01, 3'b101, 24'h3C00F0, 8'h30, 1, 1, 8'd2);
        vecs[3]  = mk(1,  0,   1,   0, 2'b01, 3'b000, 24'h3C00F0, 8'h00, 1, 1, 8'd3);
        vecs[4]  = mk(1,  0,   1,   0, 2'b01, 3'b000, 24'hFFFFFF, 8'h00, 1, 0, 8'd4);
        vecs[5]  = mk(1,  0,   1,   0, 2'b11, 3'b110, 24'h0F55AA, 8'h55, 1, 1, 8'd5);
        vecs[6]  = mk(1,  0,   1,   0, 2'b10, 3'b110, 24'h0F55AA, 8'h5A, 1, 1, 8'd6);
        vecs[7]  = mk(1,  0,   1,   0, 2'b11, 3'b111, 24'h0F55AA, 8'hAA, 1, 1, 8'd7);
        vecs[8]  = mk(1,  0,   1,   0, 2'b00, 3'b000, 24'h0F55AA, 8'h00, 1, 1, 8'd8);
        vecs[9]  = mk(1,  0,   1,   0, 2'b00, 3'b001, 24'h000081, 8'h81, 1, 1, 8'd9);
        vecs[10] = mk(1,  1,   0,   1, 2'b00, 3'b000, 24'h000000, 8'h03, 0, 1, 8'd9);
        vecs[11] = mk(1,  1,   0,   1, 2'b00, 3'b000, 24'h000000, 8'h07, 0, 1, 8'd9);
        vecs[12] = mk(1,  1,   0,   0, 2'b00, 3'b000, 24'h000000, 8'h0E, 0, 1, 8'd9);
        vecs[13] = mk(1,  0,   0,   1, 2'b00, 3'b010, 24'h004200, 8'h42, 1, 1, 8'd10);
        vecs[14] = mk(1,  1,   1,   1, 2'b00, 3'b010, 24'h004200, 8'h42, 0, 0, 8'd10);
        vecs[15] = mk(0,  0,   1,   0, 2'b00, 3'b111, 24'hFFFFFF, 8'h00, 0, 1, 8'd0);
        vecs[16] = mk(0,  1,   1,   0, 2'b00, 3'b111, 24'hFFFFFF, 8'h00, 0, 0, 8'd0);
        vecs[17] = mk(1,  0,   1,   0, 2'b10, 3'b111, 24'h010204, 8'h07, 1, 1, 8'd1);

        idle();
        rst = 1'b1;
        #3;
        checkAll("reset", 0, 8'h00, 1'b0, 1'b0, 8'd0);
        step();
        checkAll("reset_edge", 0, 8'h00, 1'b0, 1'b0, 8'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 18; i++) begin
            clearN = vecs[i].clearN; loadN = vecs[i].loadN; shiftN = vecs[i].shiftN;
            serial = vecs[i].serial; mode = vecs[i].mode; mask = vecs[i].mask; data = vecs[i].data;
            step();
            checkAll("vec", i, vecs[i].expOut, vecs[i].expDone, vecs[i].expChg, vecs[i].expCnt);
        end

        // Saturation: 300 back-to-back loads, count stops at 255.
        idle();
        clearN = 1'b0;
        step();
        clearN = 1'b1; loadN = 1'b0; mode = 2'b00; mask = 3'b111; data = 24'h000307;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 254) chk("sat_reach", i, 32'(loadCount), 32'd255);
        end
        checkAll("sat_hold", 300, 8'h07, 1'b1, 1'b0, 8'd255);
        step();
        checkAll("sat_stay", 301, 8'h07, 1'b1, 1'b0, 8'd255);
        clearN = 1'b0;
        step();
        checkAll("clr_load", 0, 8'h00, 1'b0, 1'b1, 8'd0);

        // Async reset mid-operation with a load pending.
        idle();
        loadN = 1'b0; mode = 2'b10; mask = 3'b110; data = 24'h0F55AA;
        step();
        checkAll("pre_rst", 0, 8'h5A, 1'b1, 1'b1, 8'd1);
        mask = 3'b111; data = 24'h040201;
        #5 rst = 1'b1;
        #1;
        checkAll("async_rst", 0, 8'h00, 1'b0, 1'b0, 8'd0);
        #3 rst = 1'b0;
        step();
        checkAll("post_rst", 0, 8'h07, 1'b1, 1'b1, 8'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sc_reg_general_multi.md
SC_REG_GENERAL_MULTI -- requirements
Module: sc_reg_general_multi

Interface
REQ-001 Parameter RegGENERAL_DATAWIDTH, default 8, data bit width (>=2) SHALL be provided.
REQ-002 Parameter RegGENERAL_CHANNELS, default 3, number of input channels (1..8) SHALL be provided.
REQ-003 SC_RegGENERAL_CLOCK_50  input  1  clock; all state SHALL update on its rising edge.
REQ-004 SC_RegGENERAL_RESET_InHigh  input  1  reset, asynchronous, active-high.
REQ-005 SC_RegGENERAL_clear_InLow  input  1  synchronous clear, asserted at 0.
REQ-006 SC_RegGENERAL_load_InLow  input  1  load request, asserted at 0.
REQ-007 SC_RegGENERAL_shift_InLow  input  1  shift-left request, asserted at 0.
REQ-008 SC_RegGENERAL_serial_In  input  1  bit inserted at LSB on shift.
REQ-009 SC_RegGENERAL_mode_InBUS  input  2  merge mode: 00 OR, 01 AND, 10 XOR, 11 lowest-index select.
REQ-010 SC_RegGENERAL_mask_InBUS  input  CHANNELS  per-channel enable; bit i enables channel i.
REQ-011 SC_RegGENERAL_data_InBUS  input  CHANNELS*DATAWIDTH  flattened channels; channel i at bits [i*W +: W].
REQ-012 SC_RegGENERAL_data_OutBUS  output  DATAWIDTH  stored register value.
REQ-013 SC_RegGENERAL_loadDone_Out  output  1  one-cycle pulse marking a completed load.
REQ-014 SC_RegGENERAL_changed_Out  output  1  one-cycle pulse, stored value differs from previous cycle.
REQ-015 SC_RegGENERAL_loadCount_OutBUS  output  8  saturating count of completed loads.

Function
REQ-016 Per-edge priority SHALL be: clear > load > shift > hold.
REQ-017 Clear SHALL zero the register and loadCount; loadDone SHALL stay 0 that cycle.
REQ-018 Load SHALL store the merged value of enabled channels per mode; disabled channels SHALL be ignored.
REQ-019 Mask all-zero SHALL yield merged value 0 in every mode, including AND.
REQ-020 Mode 11 SHALL select the enabled channel with the lowest index.
REQ-021 Load latency SHALL be one edge; loadDone SHALL be high exactly in the cycle the new value first appears on data_OutBUS.
REQ-022 Back-to-back loads SHALL pulse loadDone every cycle and increment loadCount each cycle.
REQ-023 loadCount SHALL saturate at 255 with no wrap.
REQ-024 Shift SHALL set register to {reg[W-2:0], serial_In}; MSB discarded.
REQ-025 changed SHALL be registered: high for one cycle when the register value differs from its previous-cycle value, regardless of cause, including clear.
REQ-026 Simultaneous clear and load SHALL clear; simultaneous load and shift SHALL load.

Reset
REQ-027 Reset SHALL force data_OutBUS=0, loadDone=0, changed=0, loadCount=0, and previous-value register=0, immediately and independent of clock.
REQ-028 Reset asserted mid-operation SHALL abort any pending load; the first edge after deassertion SHALL obey REQ-016.

Configuration
REQ-029 With SC_REG_GENERAL_MULTI_PARITY_EN defined, output SC_RegGENERAL_parity_Out (1 bit) SHALL carry the registered even parity (XOR-reduce) of data_OutBUS, reset to 0 and valid in the same cycle as data_OutBUS.
REQ-030 Without SC_REG_GENERAL_MULTI_PARITY_EN, the parity port and logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-031 Package sc_reg_general_pkg SHALL hold the mode encodings (OR/AND/XOR/SEL), loadCount width (8), and the saturation constant 255.
REQ-032 Combinational channel reduction SHALL live in sub-module sc_reg_general_merge (inputs: data, mask, mode; output: merged word); the top SHALL contain only the sequential logic.

Verification
REQ-033 W=8, C=3, mode OR, mask 111, data 0x01/0x02/0x04, load one cycle -> next cycle out=0x07, loadDone=1, changed=1, loadCount=1.
REQ-034 Mode AND, mask 101, data 0xF0/0x00/0x3C, load -> out=0x30; mask 000, load -> out=0x00.
REQ-035 Mode SEL, mask 110, data 0xAA/0x55/0x0F, load -> out=0x55; mode XOR same inputs -> out=0x5A.
REQ-036 out=0x81, shift with serial_In=1 for 2 cycles -> 0x03, then 0x07; changed high both cycles, loadDone=0.
REQ-037 Hold load asserted for 300 cycles -> loadCount=255 and stays; clear and load together -> out=0, loadCount=0, loadDone=0.
REQ-038 Reset asserted asynchronously between edges with out=0x5A -> all outputs 0 before next edge; with PARITY_EN, out=0x07 -> parity_Out=1.
